// File: rtl/adex_monitor_pkg.sv
// rtl/adex_monitor_pkg.sv - shared widths, arm-state encoding and saturating increment
// Purpose: common definitions for the spike ISI monitor slice.
// Contents: ISI_W_D / RATE_W_D default widths, arm_state_t (ST_IDLE/ST_RUN),
//           sat_inc() saturating increment helper.
package adex_monitor_pkg;

  localparam int ISI_W_D  = 16;
  localparam int RATE_W_D = 8;

  // ST_IDLE: no spike seen since reset; ST_RUN: measurement armed.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } arm_state_t;

  // Increment that sticks at max_value; callers pass their own all-ones limit.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/isi_fifo.sv
// rtl/isi_fifo.sv - small show-ahead FIFO holding measured intervals
// Purpose: circular buffer with registered pointers and occupancy.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop,
//        full, empty, count (occupancy), head (oldest entry, valid when !empty).
// The parent only pushes when !full (or together with a pop) and only pops
// when !empty; drop policy and overflow tracking live in the parent.
module isi_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  // Storage needs no reset: head is only meaningful while cnt != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so plain pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/spike_isi_monitor.sv
// rtl/spike_isi_monitor.sv - inter-spike interval and windowed rate monitor
// Purpose: measures intervals between spike pulses in enabled cycles, queues
//          them for readout, and counts spikes per fixed window.
// Ports: clk, rst_n (sync, active-low), en, spike_in,
//        isi_valid/isi_ready/isi_data (show-ahead read port), fifo_count,
//        overflow (sticky drop flag), rate_out/rate_valid, burst_det.
// Optional: define SPIKE_ISI_BURST_EN to build the short-interval burst flag;
//           otherwise burst_det is constant 0.
module spike_isi_monitor
  import adex_monitor_pkg::*;
#(
  parameter int ISI_W      = ISI_W_D,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_CYCLES = 1024,
  parameter int RATE_W     = RATE_W_D,
  parameter int BURST_THR  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        spike_in,
  output logic                        isi_valid,
  input  logic                        isi_ready,
  output logic [ISI_W-1:0]            isi_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [RATE_W-1:0]           rate_out,
  output logic                        rate_valid,
  output logic                        burst_det
);

  localparam int WIN_W = $clog2(WIN_CYCLES);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (WIN_CYCLES < 2) begin : g_bad_win
    $error("WIN_CYCLES must be at least 2");
  end
  if (BURST_THR < 0) begin : g_bad_thr
    $error("BURST_THR must be non-negative");
  end

  arm_state_t        state;
  logic [ISI_W-1:0]  isi_cnt;
  logic [ISI_W-1:0]  isi_inc;
  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] spk_cnt;
  logic [RATE_W-1:0] spk_next;
  logic              win_last;

  logic              push_req;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ISI_W-1:0]  fifo_head;

  assign isi_inc  = ISI_W'(sat_inc(32'(isi_cnt), 32'({ISI_W{1'b1}})));
  assign spk_next = spike_in ? RATE_W'(sat_inc(32'(spk_cnt), 32'({RATE_W{1'b1}})))
                             : spk_cnt;
  assign win_last = (win_cnt == WIN_W'(WIN_CYCLES - 1));

  // A completed interval exists only once armed; the first spike just arms.
  assign push_req  = en && spike_in && (state == ST_RUN);
  assign fifo_pop  = isi_valid && isi_ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  isi_fifo #(
    .WIDTH (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (isi_inc),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign isi_valid = !fifo_empty;
  assign isi_data  = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      isi_cnt    <= '0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
      if (en) begin
        if (spike_in) begin
          isi_cnt <= '0;
          state   <= ST_RUN;
        end else begin
          isi_cnt <= isi_inc;
        end

        if (win_last) begin
          win_cnt    <= '0;
          rate_out   <= spk_next;
          rate_valid <= 1'b1;
          spk_cnt    <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          spk_cnt <= spk_next;
        end
      end
    end
  end

`ifdef SPIKE_ISI_BURST_EN
  // Judged on the interval itself, before the FIFO, so drops do not hide it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_det <= 1'b0;
    end else begin
      burst_det <= push_req && (32'(isi_inc) < 32'(BURST_THR));
    end
  end
`else
  assign burst_det = 1'b0;
`endif

endmodule

// File: tb/tb_spike_isi_monitor.sv
// tb/tb_spike_isi_monitor.sv - self-checking bench for spike_isi_monitor
module tb_spike_isi_monitor;

  localparam int DEPTH   = 4;
  localparam int WIN     = 1024;
  localparam int ISI_MAX = 65535;
  localparam int RATE_MX = 255;
  localparam int THR     = 8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        spike_in;
  logic        isi_valid;
  logic        isi_ready;
  logic [15:0] isi_data;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  rate_out;
  logic        rate_valid;
  logic        burst_det;

  int checks = 0;
  int errors = 0;

  // Reference model state, in terms of enabled-cycle timestamps.
  int q[$];
  int ecyc;
  int last_spike;
  bit armed;
  bit m_ovf;
  int win_spikes;
  int m_rate;
  bit m_rv;
  bit m_burst;

  spike_isi_monitor u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike_in   (spike_in),
    .isi_valid  (isi_valid),
    .isi_ready  (isi_ready),
    .isi_data   (isi_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .burst_det  (burst_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit s, input bit rdy);
    int idx;
    int isi;
    m_burst = 1'b0;
    if (!r) begin
      q.delete();
      ecyc = 0; last_spike = 0; armed = 0; m_ovf = 0;
      win_spikes = 0; m_rate = 0; m_rv = 0;
      return;
    end
    if (q.size() > 0 && rdy) void'(q.pop_front());
    m_rv = 1'b0;
    if (e) begin
      idx = ecyc;
      ecyc++;
      if (s) begin
        if (armed) begin
          isi = idx - last_spike;
          if (isi > ISI_MAX) isi = ISI_MAX;
          m_burst = (isi < THR);
          if (q.size() < DEPTH) q.push_back(isi);
          else m_ovf = 1'b1;
        end
        armed = 1'b1;
        last_spike = idx;
        win_spikes++;
      end
      if (idx % WIN == WIN - 1) begin
        m_rate = (win_spikes > RATE_MX) ? RATE_MX : win_spikes;
        m_rv = 1'b1;
        win_spikes = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("isi_valid", 32'(isi_valid), 32'(q.size() > 0));
    chk("isi_data", 32'(isi_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rate_out", 32'(rate_out), 32'(m_rate));
    chk("rate_valid", 32'(rate_valid), 32'(m_rv));
`ifdef SPIKE_ISI_BURST_EN
    chk("burst_det", 32'(burst_det), 32'(m_burst));
`else
    chk("burst_det", 32'(burst_det), 32'd0);
`endif
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit rdy);
    rst_n = r; en = e; spike_in = s; isi_ready = rdy;
    @(posedge clk);
    model_edge(r, e, s, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    int rv_pulses;
    int bursts;
    rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; isi_ready = 1'b0;

    // Idle window: first rate pulse after WIN enabled cycles with rate 0.
    do_reset();
    rv_pulses = 0;
    for (int i = 0; i < WIN + 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      if (rate_valid) begin
        rv_pulses++;
        chk("first_rate_cycle", 32'(i), 32'(WIN - 1));
      end
    end
    chk("rate_pulses", 32'(rv_pulses), 32'd1);

    // Spikes at enabled cycles 10, 15, 40 -> entries 5, 25.
    do_reset();
    for (int i = 0; i < 46; i++) step(1'b1, 1'b1, (i == 10 || i == 15 || i == 40), 1'b0);
    chk("two_entries", 32'(fifo_count), 32'd2);
    chk("head_5", 32'(isi_data), 32'd5);

    // Six intervals into a depth-4 FIFO, then drain.
    do_reset();
    for (int g = 3; g <= 9; g++) begin
      for (int k = 0; k < g - 1; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    chk("ovf_full", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("drained", 32'(isi_valid), 32'd0);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      for (int j = 0; j < k + 1; j++) step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("pushpop_count", 32'(fifo_count), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd0);

    // en=0 gap of 50 cycles inside a 20-enabled-cycle interval, spikes ignored.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, k[0], 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap_isi", 32'(isi_data), 32'd20);
    for (int k = 0; k < WIN; k++) step(1'b1, 1'b1, 1'b0, 1'b1);

    // Intervals 5 then 12: one burst pulse at most.
    do_reset();
    bursts = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, (i == 0 || i == 5 || i == 17), 1'b1);
      if (burst_det) bursts++;
    end
`ifdef SPIKE_ISI_BURST_EN
    chk("burst_count", 32'(bursts), 32'd1);
`else
    chk("burst_count", 32'(bursts), 32'd0);
`endif

    // Spike every cycle for a full window: rate saturates.
    do_reset();
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rate_sat", 32'(rate_out), 32'd255);

    // Random traffic, with an occasional mid-stream reset.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 999) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
